// File: rtl/srb_chain_tx_if.sv
`default_nettype none
// ============================================================================
// Module      : srb_chain_tx_if
// Description : Bundle of the command handshake and SRB chain drive lines
//               for srb_chain_tx.
//               master : command source; drives cmd_*, observes everything else
//               slave  : transmitter; consumes cmd_*, drives ready/chain/status
//               Signals: cmd_valid/cmd_ready handshake, cmd_data (W),
//               cmd_len (LW), cmd_toggle (N), cmd_drain (CW), cmd_abort,
//               srb_start, srb_in, srb_toggle (N), busy, done.
// Revision    : 1.0 - initial release
// ============================================================================
interface srb_chain_tx_if #(
    parameter int N  = 12,
    parameter int W  = 16,
    parameter int LW = 5,
    parameter int CW = 8
);
    logic          cmd_valid;
    logic          cmd_ready;
    logic [W-1:0]  cmd_data;
    logic [LW-1:0] cmd_len;
    logic [N-1:0]  cmd_toggle;
    logic [CW-1:0] cmd_drain;
    logic          cmd_abort;
    logic          srb_start;
    logic          srb_in;
    logic [N-1:0]  srb_toggle;
    logic          busy;
    logic          done;

    modport master (
        output cmd_valid, cmd_data, cmd_len, cmd_toggle, cmd_drain, cmd_abort,
        input  cmd_ready, srb_start, srb_in, srb_toggle, busy, done
    );

    modport slave (
        input  cmd_valid, cmd_data, cmd_len, cmd_toggle, cmd_drain, cmd_abort,
        output cmd_ready, srb_start, srb_in, srb_toggle, busy, done
    );
endinterface
`default_nettype wire

// File: rtl/srb_chain_tx.sv
`default_nettype none
// ============================================================================
// Module      : srb_chain_tx
// Description : Command-driven transmitter for the SRB shift/shortcut chain.
//               Accepts one command (payload, bit count, toggle mask, drain
//               length), serialises the payload LSB first onto srb_in with
//               srb_start high, zero-fills for the drain length, then pulses
//               done for one cycle. cmd_abort cuts SEND/DRAIN short.
// Ports       : clk  - clock, rising edge
//               rst  - synchronous active-high reset
//               bus  - srb_chain_tx_if.slave (command handshake + chain drive)
// Revision    : 1.0 - initial release
// ============================================================================
module srb_chain_tx #(
    parameter int N  = 12,
    parameter int W  = 16,
    parameter int LW = 5,
    parameter int CW = 8
) (
    input  logic         clk,
    input  logic         rst,
    srb_chain_tx_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SEND  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [LW-1:0] c_max_len = LW'(W);
    localparam logic [LW-1:0] c_one_len = LW'(1);
    localparam logic [CW-1:0] c_one_drn = CW'(1);

    state_t        r_state;
    state_t        w_state_nxt;
    logic [W-1:0]  r_shift,   w_shift_nxt;
    logic [LW-1:0] r_bit_cnt, w_bit_cnt_nxt;
    logic [CW-1:0] r_drn_cnt, w_drn_cnt_nxt;
    logic [N-1:0]  r_toggle,  w_toggle_nxt;
    logic          r_in,      w_in_nxt;
    logic          r_start;
    logic          r_busy;
    logic          r_done;
    logic          r_ready;

    logic          w_accept;
    logic [LW-1:0] w_len_clamped;

    // r_ready is high exactly in IDLE, so this is the only accept condition.
    assign w_accept      = bus.cmd_valid && r_ready;
    assign w_len_clamped = (bus.cmd_len > c_max_len) ? c_max_len : bus.cmd_len;

    // Next-state logic. All outputs are registered from the next state, so the
    // value computed here appears on the pins in the cycle the state is entered.
    // Counters hold the number of cycles remaining including the current one.
    always_comb begin
        w_state_nxt   = r_state;
        w_shift_nxt   = r_shift;
        w_bit_cnt_nxt = r_bit_cnt;
        w_drn_cnt_nxt = r_drn_cnt;
        w_toggle_nxt  = r_toggle;
        w_in_nxt      = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    // Bit 0 goes straight to srb_in; the register keeps the rest.
                    w_shift_nxt   = bus.cmd_data >> 1;
                    w_bit_cnt_nxt = w_len_clamped;
                    w_drn_cnt_nxt = bus.cmd_drain;
                    w_toggle_nxt  = bus.cmd_toggle;
                    if (w_len_clamped != '0) begin
                        w_state_nxt = ST_SEND;
                        w_in_nxt    = bus.cmd_data[0];
                    end else if (bus.cmd_drain != '0) begin
                        w_state_nxt = ST_DRAIN;
                    end else begin
                        w_state_nxt = ST_DONE;
                    end
                end
            end
            ST_SEND: begin
                if (bus.cmd_abort) begin
                    w_state_nxt = ST_DONE;
                end else if (r_bit_cnt <= c_one_len) begin
                    w_bit_cnt_nxt = '0;
                    w_state_nxt   = (r_drn_cnt != '0) ? ST_DRAIN : ST_DONE;
                end else begin
                    w_in_nxt      = r_shift[0];
                    w_shift_nxt   = r_shift >> 1;
                    w_bit_cnt_nxt = r_bit_cnt - c_one_len;
                end
            end
            ST_DRAIN: begin
                if (bus.cmd_abort) begin
                    w_state_nxt = ST_DONE;
                end else if (r_drn_cnt <= c_one_drn) begin
                    w_drn_cnt_nxt = '0;
                    w_state_nxt   = ST_DONE;
                end else begin
                    w_drn_cnt_nxt = r_drn_cnt - c_one_drn;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_shift   <= '0;
            r_bit_cnt <= '0;
            r_drn_cnt <= '0;
            r_toggle  <= '0;
            r_in      <= 1'b0;
            r_start   <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_ready   <= 1'b1;
        end else begin
            r_state   <= w_state_nxt;
            r_shift   <= w_shift_nxt;
            r_bit_cnt <= w_bit_cnt_nxt;
            r_drn_cnt <= w_drn_cnt_nxt;
            r_toggle  <= w_toggle_nxt;
            r_in      <= w_in_nxt;
            r_start   <= (w_state_nxt == ST_SEND) || (w_state_nxt == ST_DRAIN);
            r_busy    <= (w_state_nxt != ST_IDLE);
            r_done    <= (w_state_nxt == ST_DONE);
            r_ready   <= (w_state_nxt == ST_IDLE);
        end
    end

    assign bus.cmd_ready  = r_ready;
    assign bus.srb_start  = r_start;
    assign bus.srb_in     = r_in;
    assign bus.srb_toggle = r_toggle;
    assign bus.busy       = r_busy;
    assign bus.done       = r_done;

endmodule
`default_nettype wire
